// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine.
//   sme_state_e : FSM state encoding
//   CH_*        : pattern metacharacters and the word separator
//   fold_case() : maps ASCII A-Z onto a-z, leaves every other byte alone
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV_S = 3'd1,
    ST_RECV_P = 3'd2,
    ST_SEARCH = 3'd3,
    ST_DONE   = 3'd4
  } sme_state_e;

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if ((c >= 8'h41) && (c <= 8'h5A)) begin
      fold_case = c | 8'h20;
    end else begin
      fold_case = c;
    end
  endfunction

endpackage

// File: rtl/sme_char_eq.sv
// Single-element compare of a string character against a pattern character.
//   s_char : string character
//   p_char : pattern character ('.' matches anything)
//   eq     : 1 when the pattern character accepts the string character
// Zero-width elements ('^', '$', '*') are resolved by the caller.
module sme_char_eq
  import sme_pkg::*;
#(
  parameter int CASE_INSENS = 0
) (
  input  logic [7:0] s_char,
  input  logic [7:0] p_char,
  output logic       eq
);

  // Wildcard first, then either a folded or an exact byte compare.
  always_comb begin
    if (p_char == CH_DOT) begin
      eq = 1'b1;
    end else if (CASE_INSENS != 0) begin
      eq = (fold_case(s_char) == fold_case(p_char));
    end else begin
      eq = (s_char == p_char);
    end
  end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine: stores one string and one pattern
// and reports the leftmost start index where the pattern matches.
//   clk, reset            : clock, synchronous active-high reset
//   chardata              : character sampled with isstring / ispattern
//   isstring / ispattern  : next string / pattern character (isstring wins)
//   busy                  : search in progress
//   valid                 : one-cycle result strobe
//   match, match_index    : result, held until the next valid
// The string is retained across searches; a pattern burst that is not
// preceded by a string burst runs against the retained string.
module sme_param
  import sme_pkg::*;
#(
  parameter int STR_MAX     = 32,
  parameter int PAT_MAX     = 8,
  parameter int IDX_W       = $clog2(STR_MAX),
  parameter int CASE_INSENS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
);

  // String positions need one extra bit so that slen == STR_MAX fits.
  localparam int SW = IDX_W + 1;
  localparam int PW = $clog2(PAT_MAX) + 1;
  localparam int PI = PW - 1;
  localparam logic [SW-1:0] STR_MAX_C = SW'(STR_MAX);
  localparam logic [PW-1:0] PAT_MAX_C = PW'(PAT_MAX);

  sme_state_e       state_q, state_d;
  logic [7:0]       str_q [STR_MAX];
  logic [7:0]       str_d [STR_MAX];
  logic [7:0]       pat_q [PAT_MAX];
  logic [7:0]       pat_d [PAT_MAX];
  logic [SW-1:0]    slen_q, slen_d;
  logic [PW-1:0]    plen_q, plen_d;
  logic [SW-1:0]    st_q, st_d;          // candidate start
  logic [SW-1:0]    sp_q, sp_d;          // string position
  logic [PW-1:0]    pp_q, pp_d;          // pattern position
  logic             star_v_q, star_v_d;  // a '*' has been seen in this candidate
  logic [PW-1:0]    star_p_q, star_p_d;
  logic [SW-1:0]    star_s_q, star_s_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic [IDX_W-1:0] match_index_q, match_index_d;

  logic [7:0] s_cur_s;
  logic [7:0] s_prev_s;
  logic [7:0] p_cur_s;
  logic       eq_s;
  logic       elem_ok_s;
  logic       consume_s;

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = match_index_q;

  // Current string/pattern characters; out-of-range reads return 0.
  always_comb begin
    if (sp_q < slen_q) begin
      s_cur_s = str_q[sp_q[IDX_W-1:0]];
    end else begin
      s_cur_s = 8'h00;
    end
    if ((sp_q != {SW{1'b0}}) && (sp_q <= slen_q)) begin
      s_prev_s = str_q[IDX_W'(sp_q - SW'(1))];
    end else begin
      s_prev_s = 8'h00;
    end
    if (pp_q < plen_q) begin
      p_cur_s = pat_q[pp_q[PI-1:0]];
    end else begin
      p_cur_s = 8'h00;
    end
  end

  sme_char_eq #(
    .CASE_INSENS(CASE_INSENS)
  ) u_char_eq (
    .s_char(s_cur_s),
    .p_char(p_cur_s),
    .eq    (eq_s)
  );

  // Evaluate the current non-star element: anchors are zero-width,
  // literals and '.' consume one string character.
  always_comb begin
    if (p_cur_s == CH_CARET) begin
      elem_ok_s = (sp_q == {SW{1'b0}}) || (s_prev_s == CH_SPACE);
      consume_s = 1'b0;
    end else if (p_cur_s == CH_DOLLAR) begin
      elem_ok_s = (sp_q == slen_q) || (s_cur_s == CH_SPACE);
      consume_s = 1'b0;
    end else begin
      elem_ok_s = (sp_q < slen_q) && eq_s;
      consume_s = 1'b1;
    end
  end

  // Next-state logic: input capture, search stepping and result strobe.
  always_comb begin
    state_d       = state_q;
    str_d         = str_q;
    pat_d         = pat_q;
    slen_d        = slen_q;
    plen_d        = plen_q;
    st_d          = st_q;
    sp_d          = sp_q;
    pp_d          = pp_q;
    star_v_d      = star_v_q;
    star_p_d      = star_p_q;
    star_s_d      = star_s_q;
    busy_d        = 1'b0;
    valid_d       = 1'b0;
    match_d       = match_q;
    match_index_d = match_index_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (isstring) begin
          // First character of a burst replaces the previous string.
          str_d[0] = chardata;
          slen_d   = SW'(1);
          state_d  = ST_RECV_S;
        end else if (ispattern) begin
          pat_d[0] = chardata;
          plen_d   = PW'(1);
          state_d  = ST_RECV_P;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RECV_S: begin
        if (isstring) begin
          if (slen_q < STR_MAX_C) begin
            str_d[slen_q[IDX_W-1:0]] = chardata;
            slen_d = slen_q + SW'(1);
          end else begin
            slen_d = slen_q;
          end
        end else if (ispattern) begin
          pat_d[0] = chardata;
          plen_d   = PW'(1);
          state_d  = ST_RECV_P;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RECV_P: begin
        if (ispattern && !isstring) begin
          if (plen_q < PAT_MAX_C) begin
            pat_d[plen_q[PI-1:0]] = chardata;
            plen_d = plen_q + PW'(1);
          end else begin
            plen_d = plen_q;
          end
        end else begin
          state_d  = ST_SEARCH;
          busy_d   = 1'b1;
          st_d     = {SW{1'b0}};
          sp_d     = {SW{1'b0}};
          pp_d     = {PW{1'b0}};
          star_v_d = 1'b0;
          star_p_d = {PW{1'b0}};
          star_s_d = {SW{1'b0}};
        end
      end

      ST_SEARCH: begin
        busy_d = 1'b1;
        if (pp_q >= plen_q) begin
          state_d       = ST_DONE;
          busy_d        = 1'b0;
          valid_d       = 1'b1;
          match_d       = 1'b1;
          match_index_d = st_q[IDX_W-1:0];
        end else if (p_cur_s == CH_STAR) begin
          star_v_d = 1'b1;
          star_p_d = pp_q + PW'(1);
          star_s_d = sp_q;
          pp_d     = pp_q + PW'(1);
        end else if (elem_ok_s) begin
          pp_d = pp_q + PW'(1);
          if (consume_s) begin
            sp_d = sp_q + SW'(1);
          end else begin
            sp_d = sp_q;
          end
        end else if (star_v_q && (star_s_q < slen_q)) begin
          // Let the last '*' swallow one more character and retry.
          star_s_d = star_s_q + SW'(1);
          sp_d     = star_s_q + SW'(1);
          pp_d     = star_p_q;
        end else if (st_q < slen_q) begin
          st_d     = st_q + SW'(1);
          sp_d     = st_q + SW'(1);
          pp_d     = {PW{1'b0}};
          star_v_d = 1'b0;
        end else begin
          state_d       = ST_DONE;
          busy_d        = 1'b0;
          valid_d       = 1'b1;
          match_d       = 1'b0;
          match_index_d = {IDX_W{1'b0}};
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      slen_q        <= {SW{1'b0}};
      plen_q        <= {PW{1'b0}};
      st_q          <= {SW{1'b0}};
      sp_q          <= {SW{1'b0}};
      pp_q          <= {PW{1'b0}};
      star_v_q      <= 1'b0;
      star_p_q      <= {PW{1'b0}};
      star_s_q      <= {SW{1'b0}};
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      match_index_q <= {IDX_W{1'b0}};
    end else begin
      state_q       <= state_d;
      slen_q        <= slen_d;
      plen_q        <= plen_d;
      st_q          <= st_d;
      sp_q          <= sp_d;
      pp_q          <= pp_d;
      star_v_q      <= star_v_d;
      star_p_q      <= star_p_d;
      star_s_q      <= star_s_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      match_index_q <= match_index_d;
    end
  end

  // Character storage; contents are qualified by the lengths, so no reset.
  always_ff @(posedge clk) begin
    str_q <= str_d;
    pat_q <= pat_d;
  end

endmodule

// File: tb/tb_sme_param.sv
module tb_sme_param;

  logic       clk;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       busy, valid, match;
  logic [4:0] match_index;
  logic       busy_ci, valid_ci, match_ci;
  logic [4:0] match_index_ci;

  int checks;
  int errors;
  logic       last_m_ci;
  logic [4:0] last_i_ci;

  sme_param #(.STR_MAX(32), .PAT_MAX(8), .CASE_INSENS(0)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .busy(busy), .valid(valid), .match(match),
    .match_index(match_index)
  );

  sme_param #(.STR_MAX(32), .PAT_MAX(8), .CASE_INSENS(1)) dut_ci (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .busy(busy_ci), .valid(valid_ci), .match(match_ci),
    .match_index(match_index_ci)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s, input bit is_pat);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      chardata  = s[i];
      isstring  = !is_pat;
      ispattern = is_pat;
    end
    @(negedge clk);
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
  endtask

  // Wait (bounded) for the valid strobe, check the result and the strobe width.
  task automatic wait_result(input string tag, input logic exp_m, input logic [4:0] exp_i);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && (n < 3000)) begin
      @(negedge clk);
      n++;
      if (valid) got = 1'b1;
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_match"}, 32'(match), 32'(exp_m));
    check({tag, "_index"}, 32'(match_index), 32'(exp_i));
    check({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
    last_m_ci = match_ci;
    last_i_ci = match_index_ci;
    @(negedge clk);
    check({tag, "_strobe_1cyc"}, 32'(valid), 32'd0);
  endtask

  initial begin
    string long_s;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_index", 32'(match_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic match with '.' wildcard.
    send("abcde fgh", 1'b0);
    send("c.e", 1'b1);
    @(negedge clk);
    check("c.e_busy", 32'(busy), 32'd1);
    wait_result("c.e", 1'b1, 5'd2);
    repeat (3) @(negedge clk);
    check("hold_match", 32'(match), 32'd1);
    check("hold_index", 32'(match_index), 32'd2);

    // Retained string with anchors.
    send("^fg", 1'b1);
    wait_result("caret", 1'b1, 5'd6);
    send("de$", 1'b1);
    wait_result("dollar", 1'b1, 5'd3);

    // Multiple stars, then a miss.
    send("abcde fgh", 1'b0);
    send("b*g*h", 1'b1);
    wait_result("stars", 1'b1, 5'd1);
    send("xyz", 1'b1);
    wait_result("nomatch", 1'b0, 5'd0);

    // Overflowing string: the trailing 'z' is dropped.
    long_s = "";
    for (int i = 0; i < 32; i++) long_s = {long_s, "a"};
    long_s = {long_s, "z"};
    send(long_s, 1'b0);
    send("z", 1'b1);
    wait_result("trunc_z", 1'b0, 5'd0);
    send("a$", 1'b1);
    wait_result("trunc_end", 1'b1, 5'd31);

    // Case folding: only the CASE_INSENS instance matches.
    send("Hello", 1'b0);
    send("hE", 1'b1);
    wait_result("case_sens", 1'b0, 5'd0);
    check("case_insens_match", 32'(last_m_ci), 32'd1);
    check("case_insens_index", 32'(last_i_ci), 32'd0);

    // Reset during the search aborts it without a result strobe.
    send("abcdefghijklmnop", 1'b0);
    send("zzz", 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_match", 32'(match), 32'd0);
    begin
      bit seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (valid) seen = 1'b1;
      end
      check("abort_no_strobe", 32'(seen), 32'd0);
    end
    send("ab", 1'b0);
    send("b", 1'b1);
    wait_result("after_reset", 1'b1, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
